// File: rtl/fp_align_pkg.sv
// fp_align_pkg: shared widths and lane count for the exponent-compare and align stages
package fp_align_pkg;
    localparam int EXP_W_DEF = 11;
    localparam int MAN_W_DEF = 16;
    localparam int GRD_W_DEF = 3;
    localparam int LANES     = 4;
endpackage

// File: rtl/align_lane_shift.sv
// align_lane_shift: one lane's right shift into the guard window, sticky only when ALIGN_STICKY_EN is defined
module align_lane_shift
    import fp_align_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int GRD_W = GRD_W_DEF
)(
    input  logic [EXP_W-1:0]       shift,
    input  logic [MAN_W-1:0]       man,
    output logic [MAN_W+GRD_W-1:0] aligned,
    output logic                   sticky
);
    localparam int W = MAN_W + GRD_W;
    logic [W-1:0] ext;
    assign ext     = {man, {GRD_W{1'b0}}};
    // a shift of W or more drops everything, so aligned becomes 0 without a range check
    assign aligned = ext >> shift;
`ifdef ALIGN_STICKY_EN
    // the mask covers exactly the bits pushed out; for huge shifts it is all ones, giving |man
    assign sticky  = |(ext & ~({W{1'b1}} << shift));
`else
    assign sticky  = 1'b0;
`endif
endmodule

// File: rtl/align_shift_4in.sv
// align_shift_4in: 2-stage, 4-lane mantissa aligner with valid/ready; sticky gated by ALIGN_STICKY_EN
module align_shift_4in
    import fp_align_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int GRD_W = GRD_W_DEF
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W-1:0]       iexp_max,
    input  logic [EXP_W-1:0]       ishift_0,
    input  logic [EXP_W-1:0]       ishift_1,
    input  logic [EXP_W-1:0]       ishift_2,
    input  logic [EXP_W-1:0]       ishift_3,
    input  logic                   isign_0,
    input  logic                   isign_1,
    input  logic                   isign_2,
    input  logic                   isign_3,
    input  logic [MAN_W-1:0]       iman_0,
    input  logic [MAN_W-1:0]       iman_1,
    input  logic [MAN_W-1:0]       iman_2,
    input  logic [MAN_W-1:0]       iman_3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W-1:0]       oexp_max,
    output logic [MAN_W+GRD_W-1:0] oman_0,
    output logic [MAN_W+GRD_W-1:0] oman_1,
    output logic [MAN_W+GRD_W-1:0] oman_2,
    output logic [MAN_W+GRD_W-1:0] oman_3,
    output logic                   osign_0,
    output logic                   osign_1,
    output logic                   osign_2,
    output logic                   osign_3,
    output logic                   osticky_0,
    output logic                   osticky_1,
    output logic                   osticky_2,
    output logic                   osticky_3
);
    localparam int OW = MAN_W + GRD_W;
    logic             s1_valid, s2_valid, s2_adv;
    logic [EXP_W-1:0] s1_exp, s2_exp;
    logic [EXP_W-1:0] in_shift [LANES];
    logic [MAN_W-1:0] in_man [LANES];
    logic [EXP_W-1:0] s1_shift [LANES];
    logic [MAN_W-1:0] s1_man [LANES];
    logic [OW-1:0]    sh_man [LANES];
    logic [OW-1:0]    s2_man [LANES];
    logic [LANES-1:0] in_sign, s1_sign, s2_sign, sh_sticky, s2_sticky;

    assign in_shift = '{ishift_0, ishift_1, ishift_2, ishift_3};
    assign in_man   = '{iman_0, iman_1, iman_2, iman_3};
    assign in_sign  = {isign_3, isign_2, isign_1, isign_0};
    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        align_lane_shift #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) u_shift (
            .shift  (s1_shift[k]),
            .man    (s1_man[k]),
            .aligned(sh_man[k]),
            .sticky (sh_sticky[k])
        );
    end

    // S1: capture the raw bundle whenever the stage can move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_exp   <= '0;
            s1_sign  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_shift[i] <= '0;
                s1_man[i]   <= '0;
            end
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_exp  <= iexp_max;
                s1_sign <= in_sign;
                for (int i = 0; i < LANES; i++) begin
                    s1_shift[i] <= in_shift[i];
                    s1_man[i]   <= in_man[i];
                end
            end
        end
    end

    // S2: register the shifted lanes; holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_exp    <= '0;
            s2_sign   <= '0;
            s2_sticky <= '0;
            for (int i = 0; i < LANES; i++) s2_man[i] <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_exp    <= s1_exp;
                s2_sign   <= s1_sign;
                s2_sticky <= sh_sticky;
                for (int i = 0; i < LANES; i++) s2_man[i] <= sh_man[i];
            end
        end
    end

    assign out_valid = s2_valid;
    assign oexp_max  = s2_exp;
    assign oman_0    = s2_man[0];
    assign oman_1    = s2_man[1];
    assign oman_2    = s2_man[2];
    assign oman_3    = s2_man[3];
    assign {osign_3, osign_2, osign_1, osign_0}         = s2_sign;
    assign {osticky_3, osticky_2, osticky_1, osticky_0} = s2_sticky;
endmodule

// File: tb/tb_align_shift_4in.sv
// tb_align_shift_4in: random and directed checks of align_shift_4in against an arithmetic lane model
module tb_align_shift_4in;
`ifdef ALIGN_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    typedef struct packed {
        logic [10:0]      exp;
        logic [3:0]       sign;
        logic [3:0]       sticky;
        logic [3:0][18:0] man;
    } bundle_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [10:0] iexp_max = '0, oexp_max;
    logic [10:0] ishift [4];
    logic [15:0] iman [4];
    logic [3:0]  isign = '0;
    logic [18:0] oman [4];
    logic [3:0]  osign, osticky;
    int          total = 0, bad = 0;
    bundle_t     expq[$];
    bundle_t     held;
    logic        prev_stall = 1'b0;
    logic        acc;

    align_shift_4in dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .iexp_max(iexp_max),
        .ishift_0(ishift[0]), .ishift_1(ishift[1]), .ishift_2(ishift[2]), .ishift_3(ishift[3]),
        .isign_0(isign[0]), .isign_1(isign[1]), .isign_2(isign[2]), .isign_3(isign[3]),
        .iman_0(iman[0]), .iman_1(iman[1]), .iman_2(iman[2]), .iman_3(iman[3]),
        .out_valid(out_valid), .out_ready(out_ready), .oexp_max(oexp_max),
        .oman_0(oman[0]), .oman_1(oman[1]), .oman_2(oman[2]), .oman_3(oman[3]),
        .osign_0(osign[0]), .osign_1(osign[1]), .osign_2(osign[2]), .osign_3(osign[3]),
        .osticky_0(osticky[0]), .osticky_1(osticky[1]), .osticky_2(osticky[2]), .osticky_3(osticky[3])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // mantissa scaled by 2^GRD, divided by 2^shift; sticky is any nonzero remainder
    function automatic bundle_t model(input logic [10:0] e, input logic [3:0] sg,
                                      input logic [10:0] sh [4], input logic [15:0] m [4]);
        bundle_t b;
        longint unsigned x, d;
        b.exp  = e;
        b.sign = sg;
        for (int i = 0; i < 4; i++) begin
            x = longint'(m[i]) * 8;
            if (sh[i] >= 19) begin
                b.man[i]    = '0;
                b.sticky[i] = STK && (m[i] != 0);
            end else begin
                d           = 64'd1 << sh[i];
                b.man[i]    = 19'(x / d);
                b.sticky[i] = STK && ((x % d) != 0);
            end
        end
        return b;
    endfunction

    function automatic bundle_t observed();
        bundle_t b;
        b.exp    = oexp_max;
        b.sign   = osign;
        b.sticky = osticky;
        for (int i = 0; i < 4; i++) b.man[i] = oman[i];
        return b;
    endfunction

    // compare process: checks every output transfer against the model queue and holds during stalls
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold", {out_valid, observed()}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("unexpected_out", 1, 0);
                else chk("bundle", observed(), expq.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            held       = observed();
            if (in_valid && in_ready) expq.push_back(model(iexp_max, isign, ishift, iman));
        end
    end

    task automatic step();
        #2;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bundle();
        iexp_max = 11'($urandom);
        isign    = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            iman[i]   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            ishift[i] = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(19, 2047)) : 11'($urandom_range(0, 20));
        end
    endtask

    initial begin
        int cnt;
        logic [18:0] snap;
        for (int i = 0; i < 4; i++) begin ishift[i] = '0; iman[i] = '0; end
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_oman_0", oman[0], 0);
        chk("rst_oexp", oexp_max, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        step();

        // directed literal bundle, then a zero-shift bundle right behind it
        iexp_max = 11'h3A5; isign = 4'b1010;
        iman   = '{16'h8000, 16'h00FF, 16'h0001, 16'h0001};
        ishift = '{11'd3, 11'd10, 11'd19, 11'd2047};
        in_valid = 1'b1;
        step();
        iman   = '{16'hABCD, 16'hABCD, 16'h0000, 16'hFFFF};
        ishift = '{11'd0, 11'd0, 11'd0, 11'd0};
        step();
        chk("lat_valid", out_valid, 1);
        chk("oexp", oexp_max, 11'h3A5);
        chk("osign", osign, 4'b1010);
        chk("oman_0", oman[0], 19'h08000);
        chk("osticky_0", osticky[0], 0);
        chk("oman_1", oman[1], 19'h00001);
        chk("osticky_1", osticky[1], STK);
        chk("oman_2", oman[2], 0);
        chk("osticky_2", osticky[2], STK);
        chk("oman_3", oman[3], 0);
        chk("osticky_3", osticky[3], STK);
        in_valid = 1'b0;
        step();
        chk("zs_oman_0", oman[0], 19'h55E68);
        chk("zs_oman_2", oman[2], 0);
        chk("zs_oman_3", oman[3], 19'h7FFF8);
        chk("zs_sticky", osticky, 4'b0000);
        step();
        chk("idle_valid", out_valid, 0);

        // eight back-to-back bundles must leave on eight consecutive cycles
        cnt = 0;
        in_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 8) rand_bundle(); else in_valid = 1'b0;
            step();
            if (c >= 2 && c <= 9 && out_valid) cnt++;
            if (c == 10) chk("b2b_tail", out_valid, 0);
        end
        chk("b2b_count", cnt, 8);

        // stall for five cycles under continuous input
        out_ready = 1'b0; in_valid = 1'b1; rand_bundle();
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (acc) begin cnt++; rand_bundle(); end
            if (c == 2) snap = oman[0];
        end
        chk("stall_accepts", cnt, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_oman_0", oman[0], snap);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin step(); if (acc) rand_bundle(); end
        in_valid = 1'b0;
        step(); step(); step();

        // random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (acc) rand_bundle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cnt = 0;
        while (expq.size() != 0 && cnt < 20) begin step(); cnt++; end
        chk("drain", expq.size(), 0);

        // reset with both stages full discards everything
        out_ready = 1'b0; in_valid = 1'b1; rand_bundle();
        step(); rand_bundle(); step(); step();
        chk("full_before_rst", out_valid, 1);
        #2; rst_n = 1'b0; #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_ready", in_ready, 1);
        expq.delete();
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin step(); if (out_valid) cnt++; end
        chk("no_stale_out", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/align_shift_4in.md
ALIGN_SHIFT_4IN -- requirements
Module: align_shift_4in

Interface
REQ-001 SHALL have parameter EXP_W, default 11, meaning the exponent and shift-amount width; it matches the width of the upstream exponent-compare stage.
REQ-002 SHALL have parameter MAN_W, default 16, meaning the input mantissa magnitude width, hidden bit included.
REQ-003 SHALL have parameter GRD_W, default 3, meaning the number of guard bits appended below the LSB.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the input bundle is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the bundle this cycle.
REQ-008 SHALL have port iexp_max, input, EXP_W bits: the maximum exponent from the compare stage.
REQ-009 SHALL have ports ishift_0..ishift_3, input, EXP_W bits each: the right-shift amount per lane.
REQ-010 SHALL have ports isign_0..isign_3, input, 1 bit each: the sign per lane.
REQ-011 SHALL have ports iman_0..iman_3, input, MAN_W bits each: the unsigned mantissa per lane.
REQ-012 SHALL have port out_valid, output, 1 bit: the output bundle is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the output bundle.
REQ-014 SHALL have port oexp_max, output, EXP_W bits: iexp_max carried through with the lane data.
REQ-015 SHALL have ports oman_0..oman_3, output, MAN_W+GRD_W bits each: the aligned mantissa per lane.
REQ-016 SHALL have ports osign_0..osign_3, output, 1 bit each: the sign per lane, carried through.
REQ-017 SHALL have ports osticky_0..osticky_3, output, 1 bit each: the OR of all bits shifted past the guard bits.

Function
REQ-018 SHALL be a 2-stage pipeline: S1 registers the accepted bundle; S2 registers the shifted result. Latency is exactly 2 cycles from in_valid&&in_ready to out_valid when out_ready is held high.
REQ-019 SHALL transfer on in_valid&&in_ready at the input and on out_valid&&out_ready at the output.
REQ-020 SHALL drive in_ready = !s1_valid || s2_adv, where s2_adv = !s2_valid || out_ready; in_ready SHALL be combinational from out_ready only.
REQ-021 SHALL sustain one bundle per cycle with out_ready held high, with no bubbles.
REQ-022 SHALL, while out_ready=0 with both stages full, hold every output and all stage contents stable, deassert in_ready, and lose no data.
REQ-023 SHALL form each lane as {iman_k, GRD_W'b0}, logically shift it right by ishift_k, and zero-fill from the MSB.
REQ-024 SHALL, for ishift_k >= MAN_W+GRD_W, output oman_k = 0 and osticky_k = |iman_k.
REQ-025 SHALL output oman_k = {iman_k, GRD_W'b0} and osticky_k = 0 for ishift_k = 0.
REQ-026 SHALL leave osign_k unmodified, including for a zero mantissa.
REQ-027 SHALL treat each lane independently; all four lanes and oexp_max travel as one bundle.

Reset
REQ-028 SHALL, on rst_n low and asynchronously, clear s1_valid and s2_valid, leaving out_valid=0 and in_ready=1 once reset is released.
REQ-029 SHALL reset all data outputs to 0.
REQ-030 SHALL discard in-flight bundles when reset is asserted mid-operation; no output follows reset release without new input.

Configuration
REQ-031 SHALL compute osticky_k as in REQ-017 and REQ-024 when ALIGN_STICKY_EN is defined; otherwise osticky_k SHALL be tied to 0 and no sticky logic SHALL be synthesized. Timing and handshake SHALL be identical in both builds.

Structure
REQ-032 SHALL take EXP_W, MAN_W, GRD_W defaults and the lane count (4) from the shared package fp_align_pkg, which the compare stage also uses.
REQ-033 SHALL implement the per-lane shifter and sticky logic as sub-module align_lane_shift, instantiated 4 times; it is combinational and sits between S1 and S2.

Verification
REQ-034 SHALL cover: iman_0=16'h8000, ishift_0=3, out_ready=1 -> 2 cycles later oman_0=19'h08000, osticky_0=0.
REQ-035 SHALL cover: iman_1=16'h00FF, ishift_1=10 -> oman_1=19'h00001, osticky_1=1 (ALIGN_STICKY_EN defined) or 0 (undefined).
REQ-036 SHALL cover: ishift_2=19 and ishift_3=2047 with iman=16'h0001 -> oman=0, osticky=1; ishift=0 -> oman={iman,3'b000}.
REQ-037 SHALL cover: 8 back-to-back bundles with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order.
REQ-038 SHALL cover: out_ready=0 for 5 cycles under continuous input -> in_ready falls after 2 accepts, the output stays stable, and all bundles appear in order after release.
REQ-039 SHALL cover: rst_n pulsed low with both stages full -> out_valid=0 immediately, and no stale output after release.
